// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester bridge: FSM state encoding,
// response/slave error codes and the timeout counter width helper.
package apb_pkg;

  // Bridge FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  // Response error codes; the first three match the slave's PSLVERR encoding.
  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_ADDR    = 2'b01;
  localparam logic [1:0] ERR_PARITY  = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  // Byte strobe width of the APB data path.
  localparam int STRB_WD = 4;

  // Width of a counter that must hold 0..cyc; at least one bit so a
  // disabled timeout (cyc == 0) still elaborates cleanly.
  function automatic int cnt_width(input int cyc);
    return (cyc < 1) ? 1 : $clog2(cyc + 1);
  endfunction

endpackage

// File: rtl/apb_wait_timer.sv
// Wait-state counter for the ACCESS phase. Counts enabled cycles from zero
// and flags expiry once the count sits at TIMEOUT_CYC-1, so the bridge aborts
// on the TIMEOUT_CYC-th stalled ACCESS edge. TIMEOUT_CYC == 0 never expires.
module apb_wait_timer
  import apb_pkg::*;
#(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_WD = cnt_width(TIMEOUT_CYC);

  logic [CNT_WD-1:0] count_q;

  // Counter: clear wins, otherwise step while enabled and not yet at the limit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (enable && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYC == 0) begin : g_no_timeout
      assign expired = 1'b0;
    end else begin : g_timeout
      localparam logic [CNT_WD-1:0] LIMIT = CNT_WD'(TIMEOUT_CYC - 1);
      assign expired = (count_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester bridge: turns one host command into an APB SETUP/ACCESS
// transfer, waits for PREADY (or a wait-state timeout) and returns exactly
// one response per command. Only one transfer is ever outstanding.
//
// Handshakes: a command transfers on a rising PCLK where cmd_valid and
// cmd_ready are both high; a response transfers on a rising PCLK where
// rsp_valid and rsp_ready are both high. rsp_valid, rsp_rdata and rsp_err
// stay stable from assertion until that transfer.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int DATA_WD     = 32,
  parameter int ADDR_WD     = 16,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  // host command channel
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  input  logic [STRB_WD-1:0] cmd_strb,
  // host response channel
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic [1:0]         rsp_err,
  // APB requester side
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_WD-1:0] PADDR,
  output logic [DATA_WD-1:0] PWDATA,
  output logic [STRB_WD-1:0] PSTRB,
  input  logic               PREADY,
  input  logic [DATA_WD-1:0] PRDATA,
  input  logic [1:0]         PSLVERR
);

  apb_state_e state_q;
  apb_state_e state_d;

  logic accept;
  logic access_done;
  logic access_abort;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  // PREADY takes priority over an expiring timer on the same edge.
  assign accept       = (state_q == IDLE) && cmd_valid;
  assign access_done  = (state_q == ACCESS) && PREADY;
  assign access_abort = (state_q == ACCESS) && !PREADY && timer_expired;
  assign timer_enable = (state_q == ACCESS) && !PREADY;
  assign timer_clear  = (state_q == RESP) && rsp_ready;

  apb_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wait_timer (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // State register; async reset drops PSEL/PENABLE immediately mid-transfer.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and state-decoded handshake/APB control outputs.
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          state_d = SETUP;
        end
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (access_done || access_abort) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request capture: APB address/data/strobes are frozen for the whole
  // transfer; reads drive zero data and zero strobes.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      PWRITE <= 1'b0;
      PADDR  <= '0;
      PWDATA <= '0;
      PSTRB  <= '0;
    end else if (accept) begin
      PWRITE <= cmd_write;
      PADDR  <= cmd_addr;
      PWDATA <= cmd_write ? cmd_wdata : '0;
      PSTRB  <= cmd_write ? cmd_strb : '0;
    end
  end

  // Response capture at the end of ACCESS; held until the next completion.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      rsp_rdata <= '0;
      rsp_err   <= ERR_OK;
    end else if (access_done) begin
      rsp_rdata <= PWRITE ? '0 : PRDATA;
      rsp_err   <= PSLVERR;
    end else if (access_abort) begin
      rsp_rdata <= '0;
      rsp_err   <= ERR_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge built with an 8-cycle wait timeout.
// Control pattern checks use {PSEL, PENABLE, cmd_ready, rsp_valid}:
// IDLE=0010, SETUP=1000, ACCESS=1100, RESP=0001.
module tb_apb_master_bridge;

  localparam int DATA_WD = 32;
  localparam int ADDR_WD = 16;
  localparam int TMO     = 8;

  logic               PCLK = 1'b0;
  logic               PRESETn;
  logic               cmd_valid;
  logic               cmd_ready;
  logic               cmd_write;
  logic [ADDR_WD-1:0] cmd_addr;
  logic [DATA_WD-1:0] cmd_wdata;
  logic [3:0]         cmd_strb;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [DATA_WD-1:0] rsp_rdata;
  logic [1:0]         rsp_err;
  logic               PSEL;
  logic               PENABLE;
  logic               PWRITE;
  logic [ADDR_WD-1:0] PADDR;
  logic [DATA_WD-1:0] PWDATA;
  logic [3:0]         PSTRB;
  logic               PREADY;
  logic [DATA_WD-1:0] PRDATA;
  logic [1:0]         PSLVERR;

  int checks   = 0;
  int failures = 0;

  // Clock
  always #5 PCLK = ~PCLK;

  apb_master_bridge #(
    .DATA_WD     (DATA_WD),
    .ADDR_WD     (ADDR_WD),
    .TIMEOUT_CYC (TMO)
  ) dut (
    .PCLK      (PCLK),
    .PRESETn   (PRESETn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .cmd_strb  (cmd_strb),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .PSEL      (PSEL),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PSTRB     (PSTRB),
    .PREADY    (PREADY),
    .PRDATA    (PRDATA),
    .PSLVERR   (PSLVERR)
  );

  task automatic test_reset();
    PRESETn   = 1'b0;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_strb  = '0;
    rsp_ready = 1'b0;
    PREADY    = 1'b0;
    PRDATA    = '0;
    PSLVERR   = 2'b00;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_ctrl got=%b exp=0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    checks++;
    if ({PWRITE, PADDR, PWDATA, PSTRB} !== 53'd0) begin
      failures++;
      $display("FAIL reset_apb got=%h exp=0", {PWRITE, PADDR, PWDATA, PSTRB});
    end
    checks++;
    if ({rsp_rdata, rsp_err} !== 34'd0) begin
      failures++;
      $display("FAIL reset_rsp got=%h exp=0", {rsp_rdata, rsp_err});
    end
    #2 PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL reset_release got=%b exp=0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
  endtask

  // Write 152 to addr 12 with 6 stalled ACCESS cycles.
  task automatic test_write_wait();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'd12;
    cmd_wdata = 32'd152;
    cmd_strb  = 4'b1111;
    PREADY    = 1'b0;
    PRDATA    = 32'h0000_1234;
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    cmd_wdata = 32'hFFFF_FFFF;
    cmd_addr  = 16'hFFFF;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL wr_setup_ctrl got=%b exp=1000", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    checks++;
    if ({PWRITE, PADDR, PWDATA, PSTRB} !== {1'b1, 16'd12, 32'd152, 4'b1111}) begin
      failures++;
      $display("FAIL wr_setup_apb got=%h exp=%h", {PWRITE, PADDR, PWDATA, PSTRB},
               {1'b1, 16'd12, 32'd152, 4'b1111});
    end
    @(posedge PCLK);
    for (int i = 0; i < 6; i++) begin
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1100 ||
          {PWRITE, PADDR, PWDATA, PSTRB} !== {1'b1, 16'd12, 32'd152, 4'b1111}) begin
        failures++;
        $display("FAIL wr_access_stable cyc=%0d got=%b/%h exp=1100/%h", i,
                 {PSEL, PENABLE, cmd_ready, rsp_valid}, {PWRITE, PADDR, PWDATA, PSTRB},
                 {1'b1, 16'd12, 32'd152, 4'b1111});
      end
      @(posedge PCLK);
    end
    #1 PREADY = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL wr_access_last got=%b exp=1100", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    @(posedge PCLK);
    #1 PREADY = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0001) begin
      failures++;
      $display("FAIL wr_resp_ctrl got=%b exp=0001", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    checks++;
    if ({rsp_rdata, rsp_err} !== {32'd0, 2'b00}) begin
      failures++;
      $display("FAIL wr_resp_data got=%h/%b exp=0/00", rsp_rdata, rsp_err);
    end
    @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL wr_back_idle got=%b exp=0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
  endtask

  // Read addr 34, zero wait, PRDATA=150; junk write data/strobes must not leak.
  task automatic test_read();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'd34;
    cmd_wdata = 32'hDEAD_BEEF;
    cmd_strb  = 4'b1111;
    PREADY    = 1'b1;
    PRDATA    = 32'd150;
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PWRITE, PADDR, PWDATA, PSTRB} !== {1'b0, 16'd34, 32'd0, 4'b0000}) begin
      failures++;
      $display("FAIL rd_setup_apb got=%h exp=%h", {PWRITE, PADDR, PWDATA, PSTRB},
               {1'b0, 16'd34, 32'd0, 4'b0000});
    end
    @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1100 || PSTRB !== 4'b0000 || PWDATA !== 32'd0) begin
      failures++;
      $display("FAIL rd_access got=%b/%b/%h exp=1100/0000/0",
               {PSEL, PENABLE, cmd_ready, rsp_valid}, PSTRB, PWDATA);
    end
    @(posedge PCLK);
    #1 PRDATA = 32'd0;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0001 || rsp_rdata !== 32'd150 || rsp_err !== 2'b00) begin
      failures++;
      $display("FAIL rd_resp got=%b/%0d/%b exp=0001/150/00",
               {PSEL, PENABLE, cmd_ready, rsp_valid}, rsp_rdata, rsp_err);
    end
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Three zero-wait reads with cmd_valid held: one accept every 4 cycles.
  task automatic test_back_to_back();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'd40;
    PREADY    = 1'b1;
    PRDATA    = 32'd100;
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge PCLK);
      #1 cmd_addr = 16'(41 + k);
      PRDATA = 32'(100 + k);
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1000 || PADDR !== 16'(40 + k)) begin
        failures++;
        $display("FAIL b2b_setup k=%0d got=%b/%0d exp=1000/%0d", k,
                 {PSEL, PENABLE, cmd_ready, rsp_valid}, PADDR, 40 + k);
      end
      @(posedge PCLK);
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1100) begin
        failures++;
        $display("FAIL b2b_access k=%0d got=%b exp=1100", k, {PSEL, PENABLE, cmd_ready, rsp_valid});
      end
      @(posedge PCLK);
      #1 if (k == 2) cmd_valid = 1'b0;
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0001 || rsp_rdata !== 32'(100 + k)) begin
        failures++;
        $display("FAIL b2b_resp k=%0d got=%b/%0d exp=0001/%0d", k,
                 {PSEL, PENABLE, cmd_ready, rsp_valid}, rsp_rdata, 100 + k);
      end
      @(posedge PCLK);
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
        failures++;
        $display("FAIL b2b_idle k=%0d got=%b exp=0010", k, {PSEL, PENABLE, cmd_ready, rsp_valid});
      end
    end
  endtask

  // Stalled read aborts after 8 ACCESS cycles; then PREADY on the 8th edge wins.
  task automatic test_timeout();
    for (int pass = 0; pass < 2; pass++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 16'd56;
      PREADY    = 1'b0;
      PRDATA    = 32'd77;
      rsp_ready = 1'b1;
      @(posedge PCLK);
      #1 cmd_valid = 1'b0;
      @(posedge PCLK);
      for (int i = 0; i < TMO; i++) begin
        @(negedge PCLK);
        checks++;
        if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1100) begin
          failures++;
          $display("FAIL tmo_access pass=%0d cyc=%0d got=%b exp=1100", pass, i,
                   {PSEL, PENABLE, cmd_ready, rsp_valid});
        end
        if (pass == 1 && i == TMO - 1) PREADY = 1'b1;
        @(posedge PCLK);
      end
      #1 PREADY = 1'b0;
      @(negedge PCLK);
      checks++;
      if (pass == 0) begin
        if ({rsp_valid, rsp_err} !== 3'b111 || rsp_rdata !== 32'd0) begin
          failures++;
          $display("FAIL tmo_abort got=%b%b/%0d exp=111/0", rsp_valid, rsp_err, rsp_rdata);
        end
      end else begin
        if ({rsp_valid, rsp_err} !== 3'b100 || rsp_rdata !== 32'd77) begin
          failures++;
          $display("FAIL tmo_pready_wins got=%b%b/%0d exp=100/77", rsp_valid, rsp_err, rsp_rdata);
        end
      end
      @(posedge PCLK);
      @(negedge PCLK);
    end
  endtask

  // PSLVERR=01 held under rsp_ready=0 for 5 cycles, then a read with PSLVERR=10.
  task automatic test_slverr();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 16'd60;
    PREADY    = 1'b1;
    PSLVERR   = 2'b01;
    PRDATA    = 32'd5;
    rsp_ready = 1'b0;
    @(posedge PCLK);
    #1 cmd_addr = 16'd61;
    @(posedge PCLK);
    @(posedge PCLK);
    #1 PSLVERR = 2'b00;
    PRDATA = 32'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge PCLK);
      checks++;
      if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0001 || rsp_err !== 2'b01 || rsp_rdata !== 32'd5) begin
        failures++;
        $display("FAIL err_hold cyc=%0d got=%b/%b/%0d exp=0001/01/5", i,
                 {PSEL, PENABLE, cmd_ready, rsp_valid}, rsp_err, rsp_rdata);
      end
      @(posedge PCLK);
    end
    #1 rsp_ready = 1'b1;
    PSLVERR = 2'b10;
    PRDATA  = 32'd9;
    @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL err_idle got=%b exp=0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if (PADDR !== 16'd61) begin
      failures++;
      $display("FAIL err_second_addr got=%0d exp=61", PADDR);
    end
    @(posedge PCLK);
    @(posedge PCLK);
    #1 PSLVERR = 2'b00;
    @(negedge PCLK);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 2'b10 || rsp_rdata !== 32'd9) begin
      failures++;
      $display("FAIL err_parity got=%b/%b/%0d exp=1/10/9", rsp_valid, rsp_err, rsp_rdata);
    end
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  // Reset asserted mid-ACCESS, then a fresh write completes.
  task automatic test_reset_mid();
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 16'd70;
    cmd_wdata = 32'd7;
    cmd_strb  = 4'b1111;
    PREADY    = 1'b0;
    rsp_ready = 1'b1;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1100) begin
      failures++;
      $display("FAIL rst_mid_before got=%b exp=1100", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    #2 PRESETn = 1'b0;
    #1;
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL rst_mid_async got=%b exp=0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    PREADY = 1'b1;
    @(posedge PCLK);
    #1 PRESETn = 1'b1;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0010) begin
      failures++;
      $display("FAIL rst_mid_after got=%b exp=0010", {PSEL, PENABLE, cmd_ready, rsp_valid});
    end
    cmd_valid = 1'b1;
    cmd_addr  = 16'd80;
    cmd_wdata = 32'h55;
    cmd_strb  = 4'b0011;
    @(posedge PCLK);
    #1 cmd_valid = 1'b0;
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b1000 ||
        {PWRITE, PADDR, PWDATA, PSTRB} !== {1'b1, 16'd80, 32'h55, 4'b0011}) begin
      failures++;
      $display("FAIL rst_new_setup got=%b/%h exp=1000/%h", {PSEL, PENABLE, cmd_ready, rsp_valid},
               {PWRITE, PADDR, PWDATA, PSTRB}, {1'b1, 16'd80, 32'h55, 4'b0011});
    end
    @(posedge PCLK);
    @(posedge PCLK);
    @(negedge PCLK);
    checks++;
    if ({PSEL, PENABLE, cmd_ready, rsp_valid} !== 4'b0001 || rsp_err !== 2'b00 || rsp_rdata !== 32'd0) begin
      failures++;
      $display("FAIL rst_new_resp got=%b/%b/%0d exp=0001/00/0",
               {PSEL, PENABLE, cmd_ready, rsp_valid}, rsp_err, rsp_rdata);
    end
    @(posedge PCLK);
    @(negedge PCLK);
  endtask

  initial begin
    test_reset();
    test_write_wait();
    test_read();
    test_back_to_back();
    test_timeout();
    test_slverr();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester stage directly upstream of the APB slave: converts a simple valid/ready command from the host/application side into compliant APB SETUP/ACCESS phases on PSEL/PENABLE/PADDR/PWRITE/PWDATA/PSTRB.
- Waits on PREADY, captures PRDATA/PSLVERR, and returns one response per command.
- Adds a wait-state timeout so a stalled slave (e.g. Config Space never ACKs) cannot hang the host.

Parameters:
- DATA_WD, 32, PWDATA/PRDATA/cmd_wdata/rsp_rdata width
- ADDR_WD, 16, PADDR/cmd_addr width
- TIMEOUT_CYC, 64, max ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
- PCLK  in  1  APB clock; the only clock
- PRESETn  in  1  asynchronous active-low reset
- cmd_valid  in  1  host command valid
- cmd_ready  out  1  bridge can accept a command
- cmd_write  in  1  1=write, 0=read
- cmd_addr  in  ADDR_WD  target address
- cmd_wdata  in  DATA_WD  write data
- cmd_strb  in  4  write byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  host accepts response
- rsp_rdata  out  DATA_WD  read data (0 for writes)
- rsp_err  out  2  00 ok, 01 address error, 10 parity error, 11 timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PWRITE  out  1  APB direction
- PADDR  out  ADDR_WD  APB address
- PWDATA  out  DATA_WD  APB write data
- PSTRB  out  4  APB strobes
- PREADY  in  1  slave ready
- PRDATA  in  DATA_WD  slave read data
- PSLVERR  in  2  slave error code (01 address, 10 parity)

Behaviour:
- Reset (async, PRESETn=0): state IDLE. PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_rdata, rsp_err and the timeout counter all 0. cmd_ready=1 (it is decoded as state==IDLE).
- Reset mid-transfer: PSEL/PENABLE drop immediately (asynchronously); any in-flight command is lost and no response is issued.
- FSM has four states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On a cmd_valid & cmd_ready edge: register addr/write/wdata/strb and go to SETUP.
  - Otherwise all APB outputs hold their idle value: PSEL=0, PENABLE=0.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA/PSTRB valid; go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1; APB outputs stay stable throughout.
  - PREADY=1 sampled at the edge: capture PRDATA (reads only, writes give 0) into rsp_rdata and PSLVERR into rsp_err; go to RESP.
  - PREADY=0: increment the counter. When the counter reaches TIMEOUT_CYC-1 and PREADY is still 0, abort: rsp_err=11, rsp_rdata=0, go to RESP.
  - PREADY=1 on the same edge as the timeout limit: PREADY wins and no timeout is reported.
- RESP:
  - PSEL=0, PENABLE=0; rsp_valid=1, with rsp_rdata/rsp_err held stable.
  - On rsp_ready go to IDLE and clear the counter.
  - rsp_ready may be held low indefinitely; no new command is accepted meanwhile.
- Read commands: PSTRB driven 4'b0000 and PWDATA driven 0, whatever cmd_strb/cmd_wdata are.
- Minimum latency, PREADY and rsp_ready held high: accept edge n, SETUP n+1, ACCESS n+2, rsp_valid n+3, next accept n+4. One transfer is outstanding at a time.
- Counter width is $clog2(TIMEOUT_CYC+1). With TIMEOUT_CYC=0 the counter is never compared.
- PSEL never asserts outside SETUP/ACCESS. PENABLE never asserts without PSEL.

Decomposition:
- apb_pkg holds:
  - the state encoding (IDLE=2'd0, SETUP=2'd1, ACCESS=2'd2, RESP=2'd3);
  - error codes ERR_OK/ERR_ADDR/ERR_PARITY/ERR_TIMEOUT, shared with the APB slave's PSLVERR encoding.
- One sub-module: apb_wait_timer (counter with clear, enable and expired outputs, parameterised by TIMEOUT_CYC).

Test Plan:
- Write 152 to addr 12, strb 1111; slave holds PREADY low 6 cycles → PADDR=12/PWDATA=152/PSTRB=1111 stable through ACCESS; rsp_err=00, rsp_rdata=0; PSEL low the cycle after PREADY.
- Read addr 34; slave returns PRDATA=150 with PREADY → rsp_rdata=150, rsp_err=00, PSTRB=0000 and PWDATA=0 during the transfer.
- Zero-wait back-to-back commands, rsp_ready=1 → accepts every 4 cycles; SETUP is always exactly one cycle with PENABLE=0.
- TIMEOUT_CYC=8, PREADY never asserts → abort after 8 ACCESS cycles, rsp_err=11; PREADY rising on the 8th edge instead → rsp_err=00.
- Slave completes with PSLVERR=01, then a second read completes with PSLVERR=10 → rsp_err=01, then 10; rsp_valid held while rsp_ready=0 for 5 cycles, cmd_ready=0 throughout.
- Assert PRESETn low mid-ACCESS → PSEL/PENABLE go to 0 immediately, no rsp_valid; after release cmd_ready=1 and a new write completes normally.
